// File: rtl/match_img_feeder_if.sv
// Bundle of the image-feeder buses: matcher handshake, layer counts,
// image slot outputs, status flags and the two descriptor RAM ports.
// The feeder connects as "slave"; its environment (matcher and RAMs)
// connects as "master".
interface match_img_feeder_if #(
    parameter int RCD_W  = 403,
    parameter int ADDR_W = 11,
    parameter int GRP_W  = 9
);
    logic              start;
    logic [ADDR_W-1:0] layer1_num;
    logic [ADDR_W-1:0] layer2_num;
    logic              descriptor_request;
    logic              descriptor_valid;
    logic [RCD_W-1:0]  image_R_C_D_0;
    logic [RCD_W-1:0]  image_R_C_D_1;
    logic [RCD_W-1:0]  image_R_C_D_2;
    logic [RCD_W-1:0]  image_R_C_D_3;
    logic              l1_rd_en;
    logic [ADDR_W-1:0] l1_addr;
    logic [RCD_W-1:0]  l1_dout;
    logic              l2_rd_en;
    logic [ADDR_W-1:0] l2_addr;
    logic [RCD_W-1:0]  l2_dout;
    logic [GRP_W-1:0]  group_total;
    logic [GRP_W-1:0]  group_idx;
    logic              busy;
    logic              exhausted;
    logic              overrun;

    modport slave (
        input  start, layer1_num, layer2_num, descriptor_request, l1_dout, l2_dout,
        output descriptor_valid, image_R_C_D_0, image_R_C_D_1, image_R_C_D_2,
               image_R_C_D_3, l1_rd_en, l1_addr, l2_rd_en, l2_addr,
               group_total, group_idx, busy, exhausted, overrun
    );

    modport master (
        output start, layer1_num, layer2_num, descriptor_request, l1_dout, l2_dout,
        input  descriptor_valid, image_R_C_D_0, image_R_C_D_1, image_R_C_D_2,
               image_R_C_D_3, l1_rd_en, l1_addr, l2_rd_en, l2_addr,
               group_total, group_idx, busy, exhausted, overrun
    );
endinterface

// File: rtl/match_img_feeder.sv
// Image-side sequencer for the descriptor matcher. Each request fetches the
// next 4 descriptors (layer-1 first, then layer-2) from two 1-cycle-latency
// RAMs into 4 slot registers and pulses descriptor_valid.
// Optional build macro PAD_PARTIAL_GROUP_EN: round the group count up and
// fill the unused slots of the last group with all-ones (maximum distance).
module match_img_feeder #(
    parameter int RCD_W  = 403,
    parameter int ADDR_W = 11,
    parameter int GRP_W  = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    match_img_feeder_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_VALID = 3'd4;
    localparam int IDX_W = ADDR_W + 1;

    logic [2:0]        state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0] l1_num_q, l1_num_d;
    logic [GRP_W-1:0]  grp_total_q, grp_total_d;
    logic [GRP_W-1:0]  grp_idx_q, grp_idx_d;
    logic              exh_q, exh_d;
    logic              ovr_q, ovr_d;
    // Read issued last cycle: which slot it fills and where its data comes from
    logic              cap_vld_q, cap_vld_d;
    logic [1:0]        cap_slot_q, cap_slot_d;
    logic              cap_l2_q, cap_l2_d;
    logic              cap_pad_q, cap_pad_d;
    logic [RCD_W-1:0]  img_q [4];

    logic [IDX_W-1:0]  sum;
    logic [GRP_W-1:0]  grp_calc;
    logic [IDX_W-1:0]  j;
    logic [ADDR_W-1:0] l2_off;
    logic              issue;
    logic              sel_l2;
    logic              pad_slot;
    logic [RCD_W-1:0]  cap_data;

`ifdef PAD_PARTIAL_GROUP_EN
    logic [IDX_W-1:0]  total_q, total_d;
    logic [IDX_W:0]    sum_r;
`endif

    // Group count from the incoming layer counts, plus read-index decode
    always_comb begin
        sum = {1'b0, bus.layer1_num} + {1'b0, bus.layer2_num};
`ifdef PAD_PARTIAL_GROUP_EN
        sum_r    = {1'b0, sum} + (IDX_W+1)'(3);
        grp_calc = GRP_W'(sum_r >> 2);
        pad_slot = (j >= total_q);
`else
        grp_calc = GRP_W'(sum >> 2);
        pad_slot = 1'b0;
`endif
        j        = k_q + IDX_W'(slot_q);
        issue    = (state_q == S_FETCH);
        sel_l2   = (j >= {1'b0, l1_num_q});
        l2_off   = j[ADDR_W-1:0] - l1_num_q;
        cap_data = cap_pad_q ? {RCD_W{1'b1}} : (cap_l2_q ? bus.l2_dout : bus.l1_dout);
    end

    // RAM ports and status outputs
    always_comb begin
        bus.l1_rd_en         = issue && !pad_slot && !sel_l2;
        bus.l2_rd_en         = issue && !pad_slot && sel_l2;
        bus.l1_addr          = bus.l1_rd_en ? j[ADDR_W-1:0] : '0;
        bus.l2_addr          = bus.l2_rd_en ? l2_off : '0;
        bus.descriptor_valid = (state_q == S_VALID);
        bus.busy             = (state_q == S_FETCH) || (state_q == S_DRAIN);
        bus.exhausted        = exh_q;
        bus.overrun          = ovr_q;
        bus.group_total      = grp_total_q;
        bus.group_idx        = grp_idx_q;
        bus.image_R_C_D_0    = img_q[0];
        bus.image_R_C_D_1    = img_q[1];
        bus.image_R_C_D_2    = img_q[2];
        bus.image_R_C_D_3    = img_q[3];
    end

    // Sequencer next state; start overrides everything and aborts a fetch
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        k_d         = k_q;
        l1_num_d    = l1_num_q;
        grp_total_d = grp_total_q;
        grp_idx_d   = grp_idx_q;
        exh_d       = exh_q;
        ovr_d       = 1'b0;
`ifdef PAD_PARTIAL_GROUP_EN
        total_d     = total_q;
`endif
        cap_vld_d   = issue && !bus.start;
        cap_slot_d  = slot_q;
        cap_l2_d    = sel_l2;
        cap_pad_d   = pad_slot;
        case (state_q)
            S_READY: begin
                if (bus.descriptor_request) begin
                    if (exh_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        slot_d  = 2'd0;
                    end
                end
            end
            S_FETCH: begin
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_VALID;
            S_VALID: begin
                k_d       = k_q + IDX_W'(4);
                grp_idx_d = grp_idx_q + GRP_W'(1);
                if (grp_idx_q + GRP_W'(1) == grp_total_q) exh_d = 1'b1;
                state_d   = S_READY;
            end
            default: state_d = state_q;
        endcase
        if (bus.start) begin
            state_d     = S_READY;
            slot_d      = 2'd0;
            k_d         = '0;
            l1_num_d    = bus.layer1_num;
            grp_total_d = grp_calc;
            grp_idx_d   = '0;
            exh_d       = (grp_calc == '0);
            ovr_d       = 1'b0;
`ifdef PAD_PARTIAL_GROUP_EN
            total_d     = sum;
`endif
        end
    end

    // Control and configuration registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            k_q         <= '0;
            l1_num_q    <= '0;
            grp_total_q <= '0;
            grp_idx_q   <= '0;
            exh_q       <= 1'b0;
            ovr_q       <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_slot_q  <= '0;
            cap_l2_q    <= 1'b0;
            cap_pad_q   <= 1'b0;
`ifdef PAD_PARTIAL_GROUP_EN
            total_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            k_q         <= k_d;
            l1_num_q    <= l1_num_d;
            grp_total_q <= grp_total_d;
            grp_idx_q   <= grp_idx_d;
            exh_q       <= exh_d;
            ovr_q       <= ovr_d;
            cap_vld_q   <= cap_vld_d;
            cap_slot_q  <= cap_slot_d;
            cap_l2_q    <= cap_l2_d;
            cap_pad_q   <= cap_pad_d;
`ifdef PAD_PARTIAL_GROUP_EN
            total_q     <= total_d;
`endif
        end
    end

    // Slot capture: RAM data lands one cycle after its read was issued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) img_q[i] <= '0;
        end else if (cap_vld_q) begin
            img_q[cap_slot_q] <= cap_data;
        end
    end
endmodule

// File: tb/tb_match_img_feeder.sv
// Randomized self-checking bench for match_img_feeder with directed corner
// cases. Expected slot contents and read sequences come from a flat
// descriptor-list model (layer-1 list followed by layer-2 list).
module tb_match_img_feeder;
    localparam int RCD_W  = 403;
    localparam int ADDR_W = 11;
    localparam int GRP_W  = 9;
    localparam int MEM_N  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    match_img_feeder_if #(.RCD_W(RCD_W), .ADDR_W(ADDR_W), .GRP_W(GRP_W)) bus();

    match_img_feeder #(.RCD_W(RCD_W), .ADDR_W(ADDR_W), .GRP_W(GRP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [RCD_W-1:0] l1_mem [MEM_N];
    logic [RCD_W-1:0] l2_mem [MEM_N];

    always @(posedge clk) begin
        if (bus.l1_rd_en) bus.l1_dout <= l1_mem[bus.l1_addr[5:0]];
        if (bus.l2_rd_en) bus.l2_dout <= l2_mem[bus.l2_addr[5:0]];
    end

    int n_chk = 0;
    int n_fail = 0;
    int cur_n1 = 0;
    int cur_n2 = 0;
    int rd_q[$];

    task automatic check_eq(input string tag, input logic [RCD_W-1:0] obs,
                            input logic [RCD_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RCD_W-1:0] rand_word();
        logic [RCD_W-1:0] v;
        v = '0;
        for (int i = 0; i < 13; i++) v = {v[RCD_W-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic int groups_of(input int n1, input int n2);
`ifdef PAD_PARTIAL_GROUP_EN
        return (n1 + n2 + 3) / 4;
`else
        return (n1 + n2) / 4;
`endif
    endfunction

    // Flat descriptor list: layer-1 entries, then layer-2; past the end is padding
    function automatic logic [RCD_W-1:0] exp_desc(input int j);
        if (j >= cur_n1 + cur_n2) return {RCD_W{1'b1}};
        if (j < cur_n1) return l1_mem[j];
        return l2_mem[j - cur_n1];
    endfunction

    function automatic logic [RCD_W-1:0] slot_val(input int s);
        case (s)
            0:       return bus.image_R_C_D_0;
            1:       return bus.image_R_C_D_1;
            2:       return bus.image_R_C_D_2;
            default: return bus.image_R_C_D_3;
        endcase
    endfunction

    task automatic record_reads();
        if (bus.l1_rd_en && bus.l2_rd_en) rd_q.push_back(-1);
        else if (bus.l1_rd_en) rd_q.push_back(int'(bus.l1_addr));
        else if (bus.l2_rd_en) rd_q.push_back(4096 + int'(bus.l2_addr));
    endtask

    task automatic check_buses(input string tag, input int g);
        for (int s = 0; s < 4; s++)
            check_eq($sformatf("%s_slot%0d", tag, s), slot_val(s), exp_desc(4*g + s));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, bus.descriptor_valid, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_exh"}, bus.exhausted, 0);
        check_eq({tag, "_ovr"}, bus.overrun, 0);
        check_eq({tag, "_rden"}, {bus.l1_rd_en, bus.l2_rd_en}, 0);
        check_eq({tag, "_addr"}, {bus.l1_addr, bus.l2_addr}, 0);
        check_eq({tag, "_gtot"}, bus.group_total, 0);
        check_eq({tag, "_gidx"}, bus.group_idx, 0);
        check_eq({tag, "_bus"}, bus.image_R_C_D_0 | bus.image_R_C_D_1 |
                 bus.image_R_C_D_2 | bus.image_R_C_D_3, 0);
    endtask

    task automatic do_start(input int n1, input int n2);
        bus.layer1_num = ADDR_W'(n1);
        bus.layer2_num = ADDR_W'(n2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cur_n1 = n1;
        cur_n2 = n2;
        check_eq("start_gtot", bus.group_total, groups_of(n1, n2));
        check_eq("start_exh", bus.exhausted, groups_of(n1, n2) == 0);
        check_eq("start_gidx", bus.group_idx, 0);
    endtask

    // One request/valid transaction for group g, checked against the list model
    task automatic run_group(input int g, input bit hold);
        int  cyc;
        bit  seen;
        int  exp_rd[$];
        cyc  = 0;
        seen = 1'b0;
        rd_q.delete();
        bus.descriptor_request = 1'b1;
        while (!seen && cyc < 12) begin
            tick();
            cyc++;
            record_reads();
            if (bus.descriptor_valid) seen = 1'b1;
        end
        if (!hold) bus.descriptor_request = 1'b0;
        check_eq("valid_seen", seen, 1);
        check_eq("latency", cyc, 6);
        check_eq("group_idx", bus.group_idx, g);
        check_buses("grp", g);
        for (int s = 0; s < 4; s++) begin
            int jj;
            jj = 4*g + s;
            if (jj >= cur_n1 + cur_n2) continue;
            exp_rd.push_back(jj < cur_n1 ? jj : 4096 + jj - cur_n1);
        end
        check_eq("n_reads", rd_q.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            check_eq($sformatf("read%0d", i), rd_q[i], exp_rd[i]);
        tick();
        bus.descriptor_request = 1'b0;
        check_eq("exh_after", bus.exhausted, (g + 1) == groups_of(cur_n1, cur_n2));
    endtask

    task automatic overrun_check(input int g);
        bus.descriptor_request = 1'b1;
        tick();
        bus.descriptor_request = 1'b0;
        check_eq("ovr_pulse", bus.overrun, 1);
        check_eq("ovr_rden", {bus.l1_rd_en, bus.l2_rd_en, bus.busy}, 0);
        tick();
        check_eq("ovr_drop", bus.overrun, 0);
        if (g >= 0) check_buses("ovr_hold", g);
    endtask

    initial begin
        int cnt_v;
        int cnt_r;
        int g_n;
        bus.start = 1'b0;
        bus.descriptor_request = 1'b0;
        bus.layer1_num = '0;
        bus.layer2_num = '0;
        for (int i = 0; i < MEM_N; i++) begin
            l1_mem[i] = rand_word();
            l2_mem[i] = rand_word();
        end

        // Reset state
        repeat (3) tick();
        check_idle("rst");
        rst_n = 1'b1;
        tick();

        // 5 + 3 descriptors: two groups, then exhausted and overrun
        do_start(5, 3);
        run_group(0, 1'b0);
        run_group(1, 1'b0);
        overrun_check(1);

        // 2 + 1 descriptors: empty run, or one padded group
        do_start(2, 1);
        g_n = groups_of(2, 1);
        for (int g = 0; g < g_n; g++) run_group(g, 1'b0);
        overrun_check(-1);

        // Abort at slot 2 of a fetch, then refetch from index 0
        do_start(8, 4);
        bus.descriptor_request = 1'b1;
        repeat (3) tick();
        check_eq("abort_addr", {bus.l1_rd_en, bus.l1_addr}, {1'b1, ADDR_W'(2)});
        bus.descriptor_request = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.descriptor_valid) cnt_v++;
            tick();
        end
        check_eq("abort_novalid", cnt_v, 0);
        run_group(0, 1'b0);

        // Request held through VALID: one pulse, buses stable while idle
        run_group(1, 1'b1);
        cnt_v = 0;
        cnt_r = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.descriptor_valid) cnt_v++;
            if (bus.l1_rd_en || bus.l2_rd_en) cnt_r++;
        end
        check_eq("hold_valids", cnt_v, 0);
        check_eq("hold_reads", cnt_r, 0);
        check_buses("hold", 1);

        // Reset during DRAIN, then a request without start is ignored
        bus.descriptor_request = 1'b1;
        repeat (5) tick();
        check_eq("drain_busy", {bus.busy, bus.l1_rd_en, bus.l2_rd_en}, 3'b100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("rst_drain");
        cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.busy || bus.l1_rd_en || bus.l2_rd_en || bus.descriptor_valid) cnt_v++;
        end
        bus.descriptor_request = 1'b0;
        check_eq("nostart_ignored", cnt_v, 0);

        // Randomized runs with random idle gaps between requests
        for (int r = 0; r < 8; r++) begin
            do_start($urandom_range(0, 28), $urandom_range(0, 28));
            g_n = groups_of(cur_n1, cur_n2);
            for (int g = 0; g < g_n; g++) begin
                repeat ($urandom_range(0, 3)) tick();
                run_group(g, 1'b0);
            end
            overrun_check(g_n > 0 ? g_n - 1 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
